// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, built from two half adders,
// is time-shared over WIDTH cycles (LSB first) between a valid/ready requester
// and a valid/ready consumer.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shared full-adder cell: the first half adder combines the operand bits,
    // the second folds in the running carry; either half may produce the carry.
    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic cell_s, cell_c;

    half_adder u_ha0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(ha0_s), .c_o(ha0_c));
    half_adder u_ha1 (.a_i(ha0_s),     .b_i(carry_q),   .s_o(ha1_s), .c_o(ha1_c));

    assign cell_s = ha1_s;
    assign cell_c = ha0_c | ha1_c;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath sequencing: accept in IDLE, one bit per RUN cycle,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                sum_d             = sum_q >> 1;
                sum_d[WIDTH-1]    = cell_s;
                carry_d           = cell_c;
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs follow the registered state; ready is masked while reset is held.
    assign ready_o = (state_q == S_IDLE) && !rst_i;
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q != S_IDLE);
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer addition of the operands.

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=8 instance signals
    logic       valid_i8 = 1'b0;
    logic       ready_o8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       valid_o8;
    logic       ready_i8 = 1'b0;
    logic [7:0] sum8;
    logic       carry8;
    logic       busy8;

    // WIDTH=1 instance signals
    logic       valid_i1 = 1'b0;
    logic       ready_o1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       valid_o1;
    logic       ready_i1 = 1'b0;
    logic [0:0] sum1;
    logic       carry1;
    logic       busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i8), .ready_o(ready_o8),
        .a_i(a8), .b_i(b8),
        .valid_o(valid_o8), .ready_i(ready_i8),
        .sum_o(sum8), .carry_o(carry8), .busy_o(busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i1), .ready_o(ready_o1),
        .a_i(a1), .b_i(b1),
        .valid_o(valid_o1), .ready_i(ready_i1),
        .sum_o(sum1), .carry_o(carry1), .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction, starting just after a falling edge.
    // hold = cycles of backpressure in DONE, with a competing request driven meanwhile.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [8:0] exp;
        int cyc;
        exp = {1'b0, a} + {1'b0, b};
        check("w8_ready_before", 32'(ready_o8), 1);
        valid_i8 = 1'b1;
        a8 = a;
        b8 = b;
        @(negedge clk);
        valid_i8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        check("w8_busy_after_accept", 32'(busy8), 1);
        cyc = 0;
        while (valid_o8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("w8_latency", 32'(cyc), 8);
        check("w8_sum", 32'(sum8), 32'(exp[7:0]));
        check("w8_carry", 32'(carry8), 32'(exp[8]));
        for (int h = 0; h < hold; h++) begin
            valid_i8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            check("w8_hold_valid", 32'(valid_o8), 1);
            check("w8_hold_ready", 32'(ready_o8), 0);
            check("w8_hold_result", 32'({carry8, sum8}), 32'(exp));
        end
        valid_i8 = 1'b0;
        ready_i8 = 1'b1;
        @(negedge clk);
        ready_i8 = 1'b0;
        check("w8_valid_drop", 32'(valid_o8), 0);
        check("w8_idle_after", 32'(busy8), 0);
        check("w8_ready_after", 32'(ready_o8), 1);
    endtask

    task automatic txn1(input logic a, input logic b);
        logic [1:0] exp;
        int cyc;
        exp = {1'b0, a} + {1'b0, b};
        valid_i1 = 1'b1;
        a1 = a;
        b1 = b;
        @(negedge clk);
        valid_i1 = 1'b0;
        a1 = ~a1;
        b1 = ~b1;
        cyc = 0;
        while (valid_o1 !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("w1_latency", 32'(cyc), 1);
        check("w1_result", 32'({carry1, sum1}), 32'(exp));
        ready_i1 = 1'b1;
        @(negedge clk);
        ready_i1 = 1'b0;
        check("w1_valid_drop", 32'(valid_o1), 0);
    endtask

    initial begin
        int seen;
        int cyc;

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_o8), 0);
        check("rst_valid", 32'(valid_o8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_result", 32'({carry8, sum8}), 0);
        check("rst_ready_w1", 32'(ready_o1), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_o8), 1);
        check("post_rst_ready_w1", 32'(ready_o1), 1);

        // Directed additions and carry boundaries
        txn8(8'd3, 8'd5, 0);
        txn8(8'hFF, 8'h01, 0);
        txn8(8'hFF, 8'hFF, 0);
        txn8(8'h00, 8'h00, 0);

        // Backpressure with a competing request
        txn8(8'h81, 8'h7F, 5);

        // Operand change and request pulse during RUN
        valid_i8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h3C;
        @(negedge clk);
        valid_i8 = 1'b0;
        repeat (2) @(negedge clk);
        valid_i8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        @(negedge clk);
        valid_i8 = 1'b0;
        cyc = 0;
        while (valid_o8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("run_change_valid", 32'(valid_o8), 1);
        check("run_change_result", 32'({carry8, sum8}), 32'h096);
        ready_i8 = 1'b1;
        @(negedge clk);
        ready_i8 = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy8 || valid_o8) seen++;
        end
        check("run_no_second_txn", 32'(seen), 0);

        // Reset in the middle of RUN
        valid_i8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        @(negedge clk);
        valid_i8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", 32'(valid_o8), 0);
        check("midrun_rst_ready", 32'(ready_o8), 0);
        check("midrun_rst_busy", 32'(busy8), 0);
        check("midrun_rst_result", 32'({carry8, sum8}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_post_ready", 32'(ready_o8), 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_o8) seen++;
        end
        check("midrun_no_valid", 32'(seen), 0);
        txn8(8'h10, 8'h20, 0);

        // WIDTH=1 truth table
        txn1(1'b0, 1'b0);
        txn1(1'b0, 1'b1);
        txn1(1'b1, 1'b0);
        txn1(1'b1, 1'b1);

        // Randomized traffic against integer addition
        for (int n = 0; n < 200; n++) begin
            txn8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
